// File: rtl/adxl362_spi_responder.sv
// ADXL362 register-interface model: oversampled SPI mode-0 responder with burst reads and writes.
// Define ADXL_SOFT_RESET_EN to enable the soft-reset register at 0x1F (write 0x52).
module adxl362_spi_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID_AD    = 8'hAD,
  parameter logic [7:0]  PARTID      = 8'hF2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ss,
  output logic        miso,
  input  logic [11:0] sample_x,
  input  logic [11:0] sample_y,
  input  logic [11:0] sample_z,
  input  logic        sample_valid,
  output logic [7:0]  power_ctl,
  output logic        wr_strobe,
  output logic [7:0]  wr_addr,
  output logic        busy
);
  localparam int unsigned SW   = 12;
  localparam int unsigned NREG = 15;
  localparam logic [7:0]  CMD_READ  = 8'h0B;
  localparam logic [7:0]  CMD_WRITE = 8'h0A;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_IGNORE} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d, ss_sync_q, ss_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  state_e                 state_q, state_d;
  logic                   rd_q, rd_d, load_q, load_d, miso_q, miso_d, dready_q, dready_d;
  logic                   wr_strobe_q, wr_strobe_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             rx_q, rx_d, tx_q, tx_d, addr_q, addr_d, wr_addr_q, wr_addr_d;
  logic [NREG-1:0][7:0]   regs_q, regs_d;
  logic [SW-1:0]          x_q, x_d, y_q, y_d, z_q, z_d, sh_x_q, sh_x_d, sh_y_q, sh_y_d, sh_z_q, sh_z_d;

  logic       sclk_s, mosi_s, ss_s, sclk_rise, sclk_fall, in_window, dready_clr, soft_clr;
  logic [3:0] reg_idx;
  logic [7:0] byte_in, rdata;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign byte_in   = {rx_q[6:0], mosi_s};
  assign in_window = (addr_q >= 8'h20) && (addr_q <= 8'h2E);
  assign reg_idx   = 4'(addr_q - 8'h20);

  assign miso      = miso_q;
  assign busy      = ~ss_s;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign power_ctl = regs_q[4'hD];

  // Input synchronizers and sclk edge register
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
    sclk_prev_d = sclk_s;
  end

  // Read mux; X/Y/Z come from the snapshot taken when the address byte completed
  always_comb begin
    rdata = 8'h00;
    case (addr_q)
      8'h00:   rdata = DEVID_AD;
      8'h01:   rdata = 8'h1D;
      8'h02:   rdata = PARTID;
      8'h03:   rdata = 8'h01;
      8'h0B:   rdata = {7'd0, dready_q};
      8'h0E:   rdata = sh_x_q[7:0];
      8'h0F:   rdata = {{4{sh_x_q[11]}}, sh_x_q[11:8]};
      8'h10:   rdata = sh_y_q[7:0];
      8'h11:   rdata = {{4{sh_y_q[11]}}, sh_y_q[11:8]};
      8'h12:   rdata = sh_z_q[7:0];
      8'h13:   rdata = {{4{sh_z_q[11]}}, sh_z_q[11:8]};
      default: if (in_window) rdata = regs_q[reg_idx];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    load_d      = load_q;
    miso_d      = miso_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    sh_x_d      = sh_x_q;
    sh_y_d      = sh_y_q;
    sh_z_d      = sh_z_q;
    dready_clr  = 1'b0;
    soft_clr    = 1'b0;
    if (ss_s) begin
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      load_d    = 1'b0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d   = S_CMD;
          bit_cnt_d = 3'd0;
        end
        S_CMD, S_ADDR, S_RD, S_WR: begin
          if (sclk_rise) begin
            rx_d      = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              case (state_q)
                S_CMD: begin
                  rd_d    = (byte_in == CMD_READ);
                  state_d = (byte_in == CMD_READ || byte_in == CMD_WRITE) ? S_ADDR : S_IGNORE;
                end
                S_ADDR: begin
                  addr_d  = byte_in;
                  sh_x_d  = x_q;
                  sh_y_d  = y_q;
                  sh_z_d  = z_q;
                  load_d  = rd_q;
                  state_d = rd_q ? S_RD : S_WR;
                end
                S_RD: begin
                  addr_d = addr_q + 8'd1;
                  load_d = 1'b1;
                end
                default: begin
                  addr_d = addr_q + 8'd1;
                  if (in_window) begin
                    regs_d[reg_idx] = byte_in;
                    wr_strobe_d     = 1'b1;
                    wr_addr_d       = addr_q;
                  end
`ifdef ADXL_SOFT_RESET_EN
                  else if (addr_q == 8'h1F && byte_in == 8'h52) begin
                    regs_d      = '0;
                    soft_clr    = 1'b1;
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = 8'h1F;
                  end
`endif
                end
              endcase
            end
          end else if (sclk_fall && state_q == S_RD) begin
            // First fall after a completed byte loads the next register; later falls shift
            if (load_q) begin
              miso_d     = rdata[7];
              tx_d       = {rdata[6:0], 1'b0};
              load_d     = 1'b0;
              dready_clr = (addr_q == 8'h0B);
            end else begin
              miso_d = tx_q[7];
              tx_d   = {tx_q[6:0], 1'b0};
            end
          end
        end
        default: ;
      endcase
    end
    x_d = sample_valid ? sample_x : x_q;
    y_d = sample_valid ? sample_y : y_q;
    z_d = sample_valid ? sample_z : z_q;
    dready_d = (dready_clr || soft_clr) ? 1'b0 : dready_q;
    if (sample_valid) dready_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      rd_q        <= 1'b0;
      load_q      <= 1'b0;
      miso_q      <= 1'b0;
      dready_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      addr_q      <= 8'h00;
      wr_addr_q   <= 8'h00;
      regs_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      sh_x_q      <= '0;
      sh_y_q      <= '0;
      sh_z_q      <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      rd_q        <= rd_d;
      load_q      <= load_d;
      miso_q      <= miso_d;
      dready_q    <= dready_d;
      wr_strobe_q <= wr_strobe_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      sh_x_q      <= sh_x_d;
      sh_y_q      <= sh_y_d;
      sh_z_q      <= sh_z_d;
    end
  end

endmodule

// File: tb/tb_adxl362_spi_responder.sv
// Directed bench for adxl362_spi_responder: SPI master tasks driving reads, writes, aborts and resets.
module tb_adxl362_spi_responder;
  localparam int unsigned HALF = 50;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ss = 1'b1;
  logic        miso;
  logic [11:0] sample_x = '0;
  logic [11:0] sample_y = '0;
  logic [11:0] sample_z = '0;
  logic        sample_valid = 1'b0;
  logic [7:0]  power_ctl;
  logic        wr_strobe;
  logic [7:0]  wr_addr;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int miso_hi = 0;

  adxl362_spi_responder dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z), .sample_valid(sample_valid),
    .power_ctl(power_ctl), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt++;
    if (miso === 1'b1) miso_hi++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      wait_clk(HALF);
      rx[i] = miso;
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    ss = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    ss = 1'b1;
    mosi = 1'b0;
    wait_clk(2 * HALF);
  endtask

  task automatic rd1(input logic [7:0] a, output logic [7:0] d);
    logic [7:0] junk;
    spi_begin();
    spi_bits(8'h0B, 8, junk);
    spi_bits(a, 8, junk);
    spi_bits(8'h00, 8, d);
    spi_end();
  endtask

  task automatic wr1(input logic [7:0] a, input logic [7:0] v);
    logic [7:0] junk;
    spi_begin();
    spi_bits(8'h0A, 8, junk);
    spi_bits(a, 8, junk);
    spi_bits(v, 8, junk);
    spi_end();
  endtask

  task automatic load_samples(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
    @(negedge clk);
    sample_x = x;
    sample_y = y;
    sample_z = z;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] rx, junk;
    int s0, m0;

    wait_clk(5);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_power_ctl", 32'(power_ctl), 32'h00);
    check("rst_wr_strobe", 32'(wr_strobe), 32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    wait_clk(5);

    // DEVID and 0x01 via burst read
    spi_begin();
    spi_bits(8'h0B, 8, junk);
    check("busy_cmd", 32'(busy), 32'h1);
    spi_bits(8'h00, 8, junk);
    spi_bits(8'h00, 8, rx);
    check("devid", 32'(rx), 32'hAD);
    check("busy_data", 32'(busy), 32'h1);
    spi_bits(8'h00, 8, rx);
    check("devid_next", 32'(rx), 32'h1D);
    spi_end();
    check("busy_after", 32'(busy), 32'h0);

    // Burst X/Y/Z with a new sample injected mid-burst
    load_samples(12'h801, 12'h07F, 12'h000);
    spi_begin();
    spi_bits(8'h0B, 8, junk);
    spi_bits(8'h0E, 8, junk);
    spi_bits(8'h00, 8, rx);
    check("burst_xl", 32'(rx), 32'h01);
    spi_bits(8'h00, 8, rx);
    check("burst_xh", 32'(rx), 32'hF8);
    load_samples(12'h123, 12'h07F, 12'h000);
    spi_bits(8'h00, 8, rx);
    check("burst_yl", 32'(rx), 32'h7F);
    spi_bits(8'h00, 8, rx);
    check("burst_yh", 32'(rx), 32'h00);
    spi_bits(8'h00, 8, rx);
    check("burst_zl", 32'(rx), 32'h00);
    spi_bits(8'h00, 8, rx);
    check("burst_zh", 32'(rx), 32'h00);
    spi_end();
    rd1(8'h0E, rx);
    check("x_after_update", 32'(rx), 32'h23);
    rd1(8'h0B, rx);
    check("status_ready", 32'(rx), 32'h01);
    rd1(8'h0B, rx);
    check("status_cleared", 32'(rx), 32'h00);

    // Write / readback of POWER_CTL
    s0 = strobe_cnt;
    wr1(8'h2D, 8'h02);
    check("wr_strobe_cnt", 32'(strobe_cnt - s0), 32'd1);
    check("wr_addr", 32'(wr_addr), 32'h2D);
    check("power_ctl", 32'(power_ctl), 32'h02);
    rd1(8'h2D, rx);
    check("rd_2d", 32'(rx), 32'h02);

    // Abort after 5 data bits
    s0 = strobe_cnt;
    spi_begin();
    spi_bits(8'h0A, 8, junk);
    spi_bits(8'h2D, 8, junk);
    spi_bits(8'h07, 5, junk);
    spi_end();
    check("abort_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("abort_power_ctl", 32'(power_ctl), 32'h02);
    rd1(8'h00, rx);
    check("abort_recover", 32'(rx), 32'hAD);

    // Bad command, then write to read-only 0x00
    s0 = strobe_cnt;
    m0 = miso_hi;
    spi_begin();
    spi_bits(8'h0D, 8, junk);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'hFF, 8, rx);
    spi_end();
    check("badcmd_rx", 32'(rx), 32'h00);
    wr1(8'h00, 8'h55);
    check("bad_miso_low", 32'(miso_hi - m0), 32'd0);
    check("bad_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // Window boundaries
    wr1(8'h20, 8'h5A);
    rd1(8'h20, rx);
    check("rd_20", 32'(rx), 32'h5A);
    s0 = strobe_cnt;
    wr1(8'h2F, 8'h11);
    check("wr_2f_dropped", 32'(strobe_cnt - s0), 32'd0);
    wr1(8'h2E, 8'h33);
    check("wr_2e_strobe", 32'(strobe_cnt - s0), 32'd1);
    check("wr_2e_addr", 32'(wr_addr), 32'h2E);

    // Soft reset register
    s0 = strobe_cnt;
    wr1(8'h1F, 8'h52);
    rd1(8'h20, rx);
`ifdef ADXL_SOFT_RESET_EN
    check("soft_strobe", 32'(strobe_cnt - s0), 32'd1);
    check("soft_wr_addr", 32'(wr_addr), 32'h1F);
    check("soft_power_ctl", 32'(power_ctl), 32'h00);
    check("soft_rd_20", 32'(rx), 32'h00);
`else
    check("soft_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("soft_wr_addr", 32'(wr_addr), 32'h2E);
    check("soft_power_ctl", 32'(power_ctl), 32'h02);
    check("soft_rd_20", 32'(rx), 32'h5A);
`endif

    // Address wrap 0xFF -> 0x00
    spi_begin();
    spi_bits(8'h0B, 8, junk);
    spi_bits(8'hFF, 8, junk);
    spi_bits(8'h00, 8, rx);
    check("rd_ff", 32'(rx), 32'h00);
    spi_bits(8'h00, 8, rx);
    check("wrap_00", 32'(rx), 32'hAD);
    spi_end();

    // Reset asserted mid-burst
    spi_begin();
    spi_bits(8'h0B, 8, junk);
    spi_bits(8'h00, 8, junk);
    mosi = 1'b0;
    wait_clk(HALF);
    check("pre_reset_miso", 32'(miso), 32'h1);
    reset = 1'b0;
    #1;
    check("reset_miso", 32'(miso), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    wait_clk(4);
    check("reset_power_ctl", 32'(power_ctl), 32'h00);
    ss = 1'b1;
    wait_clk(HALF);
    reset = 1'b1;
    wait_clk(HALF);
    rd1(8'h02, rx);
    check("post_reset_partid", 32'(rx), 32'hF2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adxl362_spi_responder.md
# adxl362_spi_responder

Synthesizable SPI responder (slave) that models the ADXL362 accelerometer register interface, the far end of the SPI master that feeds `accelX`/`accelY`/`accelMag` in the Nexys4 top level. It oversamples SCLK/MOSI/SS on the 100 MHz system clock, decodes ADXL362 read and write commands, and returns register bytes on MISO. Acceleration samples come from a parallel source such as a bench, a switch pattern or a Pmod loopback. The accelerometer path can then be exercised in simulation and on-board without the physical sensor.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on sclk/mosi/ss; legal values 2–3.
- `DEVID_AD`, 8'hAD: value returned at address 0x00.
- `PARTID`, 8'hF2: value returned at address 0x02.

Ports:
- `clk`  in  1  100 MHz system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0).
- `mosi`  in  1  master data out, MSB first.
- `ss`  in  1  chip select, active-low.
- `miso`  out  1  responder data; driven 0 while ss high.
- `sample_x`, `sample_y`, `sample_z`  in  12 each  signed acceleration samples.
- `sample_valid`  in  1  1-clk strobe that loads the three samples.
- `power_ctl`  out  8  current contents of register 0x2D.
- `wr_strobe`  out  1  1-clk pulse per committed register write.
- `wr_addr`  out  8  address of the last committed write.
- `busy`  out  1  high while a transaction is in progress (ss low).

## Operation
- Inputs pass through `SYNC_STAGES` flops, then one edge register. A rise/fall of synchronized sclk yields a 1-clk event.
- FSM states:
  - IDLE: ss falling → CMD.
  - CMD: after 8 sclk rises, the byte is 0x0B (read) or 0x0A (write) → ADDR. Any other value → IGNORE.
  - ADDR: after 8 rises → RD or WR.
  - RD and WR loop per byte until ss rises.
  - IGNORE: miso stays 0 until ss rises.
  - ss rising in any state → IDLE within one event cycle. A partial byte is discarded and no write is committed.
- Address auto-increments after each data byte and wraps 0xFF→0x00.
- Register map (read):
  - 0x00 DEVID_AD; 0x01 0x1D; 0x02 PARTID; 0x03 0x01.
  - 0x0B STATUS: bit0 DATA_READY.
  - 0x0E/0x0F X L/H; 0x10/0x11 Y; 0x12/0x13 Z. H = {4{sign}}, sample[11:8]; L = sample[7:0].
  - 0x20–0x2E: writable, read back as written; reset 0x00.
  - All other addresses read 0x00.
- Snapshot coherence: X/Y/Z are copied into a shadow set when the ADDR byte completes. A burst read never mixes samples. A sample_valid during the burst updates only the live set.
- DATA_READY is set by sample_valid and cleared when the STATUS byte is loaded for shifting. If both happen in the same clk, set wins.
- Writes are legal only to 0x20–0x2E (and 0x1F, see Configuration). A write commits on the 8th rise of the data byte and pulses `wr_strobe` with `wr_addr`. Writes elsewhere are dropped with no strobe.

## Timing
- Reset values: miso=0, power_ctl=0x00, wr_strobe=0, wr_addr=0x00, busy=0, FSM=IDLE, samples=0, DATA_READY=0.
- Input-to-event latency is SYNC_STAGES+1 clk. sclk high and low phases must each be ≥ SYNC_STAGES+3 clk, so sclk ≤ clk/10 (1 MHz nominal).
- MOSI is sampled on the sclk rise event.
- MISO shifts on the fall event. The MSB of a read byte is loaded and driven on the fall that follows the 8th rise of the previous byte.
- `busy` follows synchronized ss with SYNC_STAGES latency.
- `wr_strobe` is asserted 1 clk after the commit rise event.
- `power_ctl` updates in the same clk as wr_strobe.

## Configuration
- `ADXL_SOFT_RESET_EN`:
  - Defined: writing 0x52 to 0x1F returns registers 0x20–0x2E, power_ctl and DATA_READY to their reset values on the commit clk, and pulses wr_strobe with wr_addr=0x1F. Writing any other value to 0x1F is ignored.
  - Undefined: address 0x1F is read-only 0x00 and writes to it are dropped with no strobe.

## Test plan
- Read DEVID: ss low, send 0x0B, 0x00, then 2 dummy bytes at sclk=1 MHz → MISO returns 0xAD then 0x1D. busy is high for the whole transfer.
- Burst X/Y/Z: load x=12'h801, y=12'h07F, z=12'h000. Read from 0x0E, 6 bytes, with a sample_valid (x=12'h123) injected mid-burst → 0x01,0xF8,0x7F,0x00,0x00,0x00. A following read of 0x0E → 0x23.
- Write/readback: write 0x02 to 0x2D → wr_strobe 1 clk, wr_addr=0x2D, power_ctl=0x02. Reading 0x2D returns 0x02.
- Abort: write command to 0x2D, ss raised after 5 data bits → no wr_strobe, power_ctl unchanged, next transaction decodes normally.
- Bad command 0x0D, and a write to 0x00 → MISO 0 throughout, no wr_strobe.
- Soft reset (macro defined): after power_ctl=0x02, write 0x52 to 0x1F → power_ctl=0x00, 0x20 reads 0x00. With macro undefined: power_ctl stays 0x02. In both cases, reset asserted mid-burst forces miso=0 and busy=0 immediately.
